seq_alu: RTL and testbench

Parametrised, handshaked successor to the core's 64-bit combinational ALU. It adds a registered result, a valid/ready handshake on input and output, extra single-cycle ops (XOR, SLT, SLTU), and an iterative multiply/divide path that takes one bit per cycle. It sits between the decode/operand-read stage and writeback, and stalls the pipeline through `in_ready` while a multi-cycle op is in flight.

---
 rtl/seq_alu.sv | 100 ++++++++++
 tb/tb_seq_alu.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered result; define SEQ_ALU_MULDIV_EN for iterative MUL/DIVU/REMU
module seq_alu #(
  parameter int XLEN = 64,
  parameter int CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [3:0]      alu_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);
`ifdef SEQ_ALU_MULDIV_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
  typedef enum logic [0:0] {IDLE, DONE} state_t;
`endif
  state_t state, state_n, start_st;
  logic take, md;
  logic [XLEN-1:0] alu_res;
  assign take = in_valid & in_ready;
  assign zero = ~|result;
  always_comb begin
    alu_res = op1;
    case (alu_sel)
      4'b0000: alu_res = op1 & op2;
      4'b0001: alu_res = op1 | op2;
      4'b0010: alu_res = op1 + op2;
      4'b0110: alu_res = op1 - op2;
      4'b0011: alu_res = op1 ^ op2;
      4'b0111: alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
      4'b0101: alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
      default: ;
    endcase
  end
`ifdef SEQ_ALU_MULDIV_EN
  logic [CNTW-1:0] cnt;
  logic [XLEN-1:0] a, b, c, md_res;
  logic [XLEN:0]   t, diff;
  logic [1:0]      md_op;
  logic            neg;
  assign md = alu_sel[3] & ~alu_sel[2] & ~(alu_sel[1] & alu_sel[0]);
  assign start_st = md ? BUSY : DONE;
  // a: accumulator/remainder, b: multiplicand/quotient, c: multiplier/divisor
  assign t = {a, b[XLEN-1]};
  assign diff = t - {1'b0, c};
  assign neg = diff[XLEN];
  assign md_res = md_op == 2'b01 ? b : a;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (take && md) begin
      a <= '0;
      b <= op1;
      c <= op2;
      md_op <= alu_sel[1:0];
      cnt <= CNTW'(XLEN);
    end else if (state == BUSY && cnt != '0) begin
      a <= md_op == 2'b00 ? a + (c[0] ? b : '0) : (neg ? t[XLEN-1:0] : diff[XLEN-1:0]);
      b <= md_op == 2'b00 ? b << 1 : {b[XLEN-2:0], ~neg};
      c <= md_op == 2'b00 ? c >> 1 : c;
      cnt <= cnt - CNTW'(1);
    end
`else
  assign md = 1'b0;
  assign start_st = DONE;
`endif
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    in_ready = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = start_st;
      end
`ifdef SEQ_ALU_MULDIV_EN
      BUSY: if (cnt == '0) state_n = DONE;
`endif
      DONE: begin
        out_valid = 1'b1;
        in_ready = out_ready;
        if (out_ready) state_n = in_valid ? start_st : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) result <= '0;
    else if (take && !md) result <= alu_res;
`ifdef SEQ_ALU_MULDIV_EN
    else if (state == BUSY && cnt == '0) result <= md_res;
`endif
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed literal cases plus randomized traffic checked every cycle against a latency/result model
module tb_seq_alu;
  localparam int XLEN = 64;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, zero;
  logic [XLEN-1:0] op1 = '0, op2 = '0, result;
  logic [3:0] alu_sel = '0;
  int checks = 0, failures = 0;
  bit armed = 0;
  seq_alu #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .alu_sel(alu_sel), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] model_op(input logic [3:0] s, input logic [63:0] x, input logic [63:0] y);
    case (s)
      4'h0: return x & y;
      4'h1: return x | y;
      4'h2: return x + y;
      4'h6: return x - y;
      4'h3: return x ^ y;
      4'h7: return {63'd0, $signed(x) < $signed(y)};
      4'h5: return {63'd0, x < y};
`ifdef SEQ_ALU_MULDIV_EN
      4'h8: return x * y;
      4'h9: return y == 0 ? '1 : x / y;
      4'hA: return y == 0 ? x : x % y;
`endif
      default: return x;
    endcase
  endfunction
  function automatic bit is_md(input logic [3:0] s);
`ifdef SEQ_ALU_MULDIV_EN
    return s == 4'h8 || s == 4'h9 || s == 4'hA;
`else
    return 1'b0;
`endif
  endfunction
  // Model: one outstanding op, visible from cycle m_vld until handed off
  bit m_pend = 0;
  longint cyc = 0, m_vld = 0;
  logic [63:0] m_res = '0;
  always @(posedge clk) begin
    bit v, rdy;
    v = m_pend && cyc >= m_vld;
    rdy = !m_pend || (v && out_ready);
    cyc++;
    if (rst) m_pend = 0;
    else begin
      if (v && out_ready) m_pend = 0;
      if (in_valid && rdy) begin
        m_pend = 1;
        m_res = model_op(alu_sel, op1, op2);
        m_vld = cyc + (is_md(alu_sel) ? XLEN + 1 : 0);
      end
    end
  end
  always @(negedge clk) if (armed) begin
    bit v;
    v = m_pend && cyc >= m_vld;
    chk("out_valid", out_valid, v);
    chk("in_ready", in_ready, !m_pend || (v && out_ready));
    if (v) begin
      chk("result", result, m_res);
      chk("zero", zero, m_res == 0);
    end
  end
  task automatic issue(input logic [3:0] s, input logic [63:0] x, input logic [63:0] y);
    int n = 0;
    in_valid = 1; alu_sel = s; op1 = x; op2 = y;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    chk("accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0; op1 = {$urandom, $urandom}; op2 = {$urandom, $urandom}; alu_sel = 4'($urandom);
  endtask
  task automatic wait_out(input string name, input logic [63:0] exp, input int exp_lat);
    int lat = 0, busy_rdy = 0;
    @(negedge clk);
    while (!out_valid && lat < 200) begin busy_rdy += int'(in_ready); @(negedge clk); lat++; end
    chk({name, "_lat"}, lat, exp_lat);
    chk(name, result, exp);
    chk({name, "_zero"}, zero, exp == 0);
    if (exp_lat > 0) chk({name, "_busy_ready"}, busy_rdy, 0);
  endtask
  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1 rst = 0; armed = 1;
    @(negedge clk);
    chk("reset_result", result, 0);
    chk("reset_zero", zero, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk); #1;
    issue(4'h2, 5, 7);          wait_out("add", 12, 0);
    issue(4'h6, 3, 3);          wait_out("sub", 0, 0);
    issue(4'h7, '1, 1);         wait_out("slt", 1, 0);
    issue(4'h5, '1, 1);         wait_out("sltu", 0, 0);
    issue(4'h3, 'hF0, 'hFF);    wait_out("xor", 'h0F, 0);
    issue(4'h0, 'hC, 'hA);      wait_out("and", 'h8, 0);
    issue(4'h1, 'hC, 'hA);      wait_out("or", 'hE, 0);
    issue(4'hF, 'h55, 'hAA);    wait_out("dflt", 'h55, 0);
`ifdef SEQ_ALU_MULDIV_EN
    issue(4'h8, 64'hFFFF_FFFF, 64'h1_0000_0001); wait_out("mul", '1, XLEN + 1);
    issue(4'h9, 100, 7);        wait_out("divu", 14, XLEN + 1);
    issue(4'hA, 100, 7);        wait_out("remu", 2, XLEN + 1);
    issue(4'h9, 'h1234, 0);     wait_out("divu0", '1, XLEN + 1);
    issue(4'hA, 'h1234, 0);     wait_out("remu0", 'h1234, XLEN + 1);
`else
    issue(4'h8, 6, 7);          wait_out("mul_off", 6, 0);
    issue(4'h9, 100, 7);        wait_out("divu_off", 100, 0);
`endif
    issue(4'h2, 40, 2);
    out_ready = 0;
    wait_out("hold_add", 42, 0);
    repeat (5) begin
      @(negedge clk);
      chk("hold_result", result, 42);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_valid", out_valid, 1);
    end
    out_ready = 1;
    @(negedge clk);
    chk("hold_drop", out_valid, 0);
    @(posedge clk); #1;
`ifdef SEQ_ALU_MULDIV_EN
    issue(4'h8, 3, 5);
    repeat (9) @(posedge clk);
`else
    out_ready = 0;
    issue(4'h2, 3, 5);
`endif
    #1 rst = 1;
    @(posedge clk); #1 rst = 0; out_ready = 1;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    seen = 0;
    repeat (80) begin seen += int'(out_valid); @(negedge clk); end
    chk("abort_no_output", seen, 0);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst = $urandom_range(0, 299) == 0;
      in_valid = $urandom_range(0, 2) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 9) == 0) alu_sel = 4'(8 + $urandom_range(0, 2));
      else alu_sel = 4'($urandom);
      op1 = $urandom_range(0, 3) == 0 ? 64'($urandom_range(0, 300)) : {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: op2 = '0;
        1: op2 = 64'($urandom_range(1, 20));
        2: op2 = op1;
        default: op2 = {$urandom, $urandom};
      endcase
    end
    @(posedge clk); #1;
    rst = 0; in_valid = 0; out_ready = 1;
    repeat (100) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
